// File: rtl/month_year_counter_if.sv
// Bundle between the day counter and the month/year counter.
// The master drives the mode, set and carry inputs; the slave (the counter)
// returns the current month, year, leap flag and millennium carry.
interface month_year_counter_if #(
  parameter int YEAR_W = 12
);
  logic              ctrl_set;
  logic              sel_year;
  logic              inc;
  logic              dec;
  logic              carry_in_day;
  logic [3:0]        month_count;
  logic [YEAR_W-1:0] year_count;
  logic              is_leap_year;
  logic              carry_out;

  modport master (
    output ctrl_set, sel_year, inc, dec, carry_in_day,
    input  month_count, year_count, is_leap_year, carry_out
  );

  modport slave (
    input  ctrl_set, sel_year, inc, dec, carry_in_day,
    output month_count, year_count, is_leap_year, carry_out
  );
endinterface

// File: rtl/month_year_counter.sv
// Month (1..12) and year (YEAR_MIN..YEAR_MAX) counter fed by the day counter's
// end-of-month carry, with manual inc/dec of either field in set mode.
// Leap status comes from year residues kept in step with the year register,
// so no divider is needed.
// Optional feature: define GREGORIAN_CENTURY_EN to add the mod-100/mod-400
// century rule; without it a year is leap whenever it is divisible by 4.
module month_year_counter #(
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2999,
  parameter int YEAR_W   = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  month_year_counter_if.slave  bus
);

  localparam logic [YEAR_W-1:0] YEAR_MIN_C = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] YEAR_MAX_C = YEAR_W'(YEAR_MAX);
  localparam logic [1:0]        R4_MIN     = 2'(YEAR_MIN % 4);
  localparam logic [1:0]        R4_MAX     = 2'(YEAR_MAX % 4);
`ifdef GREGORIAN_CENTURY_EN
  localparam logic [6:0]        R100_MIN   = 7'(YEAR_MIN % 100);
  localparam logic [6:0]        R100_MAX   = 7'(YEAR_MAX % 100);
  localparam logic [8:0]        R400_MIN   = 9'(YEAR_MIN % 400);
  localparam logic [8:0]        R400_MAX   = 9'(YEAR_MAX % 400);
`endif

  logic [3:0]        r_month;
  logic [YEAR_W-1:0] r_year;
  logic [1:0]        r_r4;
`ifdef GREGORIAN_CENTURY_EN
  logic [6:0]        r_r100;
  logic [8:0]        r_r400;
`endif

  logic w_month_inc;
  logic w_month_dec;
  logic w_year_inc;
  logic w_year_dec;
  logic w_at_max;
  logic w_at_min;
  logic w_leap;

  assign w_at_max = (r_year == YEAR_MAX_C);
  assign w_at_min = (r_year == YEAR_MIN_C);

  // Decode the single step (if any) each field takes this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    w_month_inc = 1'b0;
    w_month_dec = 1'b0;
    w_year_inc  = 1'b0;
    w_year_dec  = 1'b0;
    if (!bus.ctrl_set) begin
      if (bus.carry_in_day) begin
        w_month_inc = 1'b1;
        w_year_inc  = (r_month == 4'd12);
      end
    end else if (bus.sel_year) begin
      w_year_inc = bus.inc;
      w_year_dec = !bus.inc && bus.dec;
    end else begin
      w_month_inc = bus.inc;
      w_month_dec = !bus.inc && bus.dec;
    end
  end

  // Month register: wraps 12->1 upward and 1->12 downward.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_month <= 4'd1;
    end else if (w_month_inc) begin
      r_month <= (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
    end else if (w_month_dec) begin
      r_month <= (r_month == 4'd1) ? 4'd12 : r_month - 4'd1;
    end
  end

  // Year register and its mod-4 residue, reloaded from constants on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_year <= YEAR_MIN_C;
      r_r4   <= R4_MIN;
    end else if (w_year_inc) begin
      if (w_at_max) begin
        r_year <= YEAR_MIN_C;
        r_r4   <= R4_MIN;
      end else begin
        r_year <= r_year + YEAR_W'(1);
        r_r4   <= r_r4 + 2'd1;
      end
    end else if (w_year_dec) begin
      if (w_at_min) begin
        r_year <= YEAR_MAX_C;
        r_r4   <= R4_MAX;
      end else begin
        r_year <= r_year - YEAR_W'(1);
        r_r4   <= r_r4 - 2'd1;
      end
    end
  end

`ifdef GREGORIAN_CENTURY_EN
  // Century residues track the year register step for step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r100 <= R100_MIN;
      r_r400 <= R400_MIN;
    end else if (w_year_inc) begin
      if (w_at_max) begin
        r_r100 <= R100_MIN;
        r_r400 <= R400_MIN;
      end else begin
        r_r100 <= (r_r100 == 7'd99)  ? 7'd0 : r_r100 + 7'd1;
        r_r400 <= (r_r400 == 9'd399) ? 9'd0 : r_r400 + 9'd1;
      end
    end else if (w_year_dec) begin
      if (w_at_min) begin
        r_r100 <= R100_MAX;
        r_r400 <= R400_MAX;
      end else begin
        r_r100 <= (r_r100 == 7'd0) ? 7'd99  : r_r100 - 7'd1;
        r_r400 <= (r_r400 == 9'd0) ? 9'd399 : r_r400 - 9'd1;
      end
    end
  end

  assign w_leap = (r_r4 == 2'd0) && ((r_r100 != 7'd0) || (r_r400 == 9'd0));
`else
  assign w_leap = (r_r4 == 2'd0);
`endif

  assign bus.month_count  = r_month;
  assign bus.year_count   = r_year;
  assign bus.is_leap_year = w_leap;
  assign bus.carry_out    = !bus.ctrl_set && bus.carry_in_day &&
                            (r_month == 4'd12) && w_at_max;

endmodule

// File: tb/tb_month_year_counter.sv
// Self-checking bench for month_year_counter: a table of single-cycle vectors,
// hand-written sequences for reset, year sweeps across century boundaries,
// and a random-carry soak through a full millennium wrap.
module tb_month_year_counter;

  localparam int YEAR_W = 12;

  logic clk;
  logic rst_n;

  month_year_counter_if #(.YEAR_W(YEAR_W)) bus ();

  month_year_counter #(
    .YEAR_MIN(2000),
    .YEAR_MAX(2999),
    .YEAR_W  (YEAR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        c;
    logic        s;
    logic        i;
    logic        d;
    logic        cy;
    logic [3:0]  m;
    logic [11:0] y;
    logic        co;
  } vec_t;

  vec_t vecs [12];

  // soak state
  int   sk_m;
  int   sk_y;
  int   sk_carries;
  int   sk_pulses;
  logic sk_cy;
  logic sk_co;
  int   yy;

  function automatic logic ref_leap(input int y);
`ifdef GREGORIAN_CENTURY_EN
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
`else
    return (y % 4 == 0);
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic s, input logic i,
                       input logic d, input logic cy);
    bus.ctrl_set     = c;
    bus.sel_year     = s;
    bus.inc          = i;
    bus.dec          = d;
    bus.carry_in_day = cy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply inputs away from the edge, check the combinational carry before the
  // edge and the registered results just after it.
  task automatic step_check(input string tag, input logic c, input logic s,
                            input logic i, input logic d, input logic cy,
                            input int exp_m, input int exp_y, input logic exp_co);
    @(negedge clk);
    drive(c, s, i, d, cy);
    #1;
    check({tag, " carry_out"}, int'(bus.carry_out), int'(exp_co));
    @(posedge clk);
    #1;
    check({tag, " month"}, int'(bus.month_count), exp_m);
    check({tag, " year"},  int'(bus.year_count),  exp_y);
    check({tag, " leap"},  int'(bus.is_leap_year), int'(ref_leap(exp_y)));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //            c     s     i     d     cy    month  year      co
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd12, 12'd2000, 1'b0}; // month dec 1->12
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1,  12'd2000, 1'b0}; // inc wins 12->1
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  12'd2000, 1'b0}; // carry ignored in set
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd12, 12'd2000, 1'b0}; // month dec 1->12
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd12, 12'd2999, 1'b0}; // year dec 2000->2999
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  12'd2000, 1'b1}; // millennium rollover
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2,  12'd2000, 1'b0}; // plain month advance
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2,  12'd2000, 1'b0}; // inc/dec ignored
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3,  12'd2000, 1'b0}; // month inc
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3,  12'd2001, 1'b0}; // year inc
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  12'd2000, 1'b0}; // year dec
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  12'd2001, 1'b0}; // inc wins on year

    // 1. Reset values
    #12;
    check("reset month", int'(bus.month_count), 1);
    check("reset year",  int'(bus.year_count), 2000);
    check("reset leap",  int'(bus.is_leap_year), 1);
    check("reset carry_out", int'(bus.carry_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int k = 0; k < 12; k++) begin
      step_check($sformatf("vec%0d", k), vecs[k].c, vecs[k].s, vecs[k].i,
                 vecs[k].d, vecs[k].cy, int'(vecs[k].m), int'(vecs[k].y), vecs[k].co);
    end

    // Asynchronous reset mid-count, no clock edge in between
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst month", int'(bus.month_count), 1);
    check("async rst year",  int'(bus.year_count), 2000);
    check("async rst leap",  int'(bus.is_leap_year), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step_check("post rst carry", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2000, 1'b0);

    // 2. December 2023 -> January 2024
    do_reset();
    step_check("to dec", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12, 2000, 1'b0);
    for (int k = 1; k <= 23; k++) begin
      step_check("to 2023", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12, 2000 + k, 1'b0);
    end
    step_check("nye 2023", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 2024, 1'b0);
    check("2024 leap", int'(bus.is_leap_year), 1);

    // 5. Year sweeps: up across 2100/2400, then down through the wrap
    do_reset();
    step_check("ydec 2000", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2999, 1'b0);
    check("2999 leap", int'(bus.is_leap_year), 0);
    step_check("yinc 2999", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 2000, 1'b0);
    yy = 2000;
    for (int k = 0; k < 400; k++) begin
      yy = yy + 1;
      step_check("yinc sweep", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, yy, 1'b0);
      if (yy == 2100) begin
`ifdef GREGORIAN_CENTURY_EN
        check("2100 leap", int'(bus.is_leap_year), 0);
`else
        check("2100 leap", int'(bus.is_leap_year), 1);
`endif
      end
    end
    check("2400 leap", int'(bus.is_leap_year), 1);
    for (int k = 0; k < 401; k++) begin
      yy = (yy == 2000) ? 2999 : yy - 1;
      step_check("ydec sweep", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, yy, 1'b0);
    end
    check("sweep end year", int'(bus.year_count), 2999);

    // 6. Random-carry soak across a full millennium wrap
    do_reset();
    sk_m = 1;
    sk_y = 2000;
    sk_carries = 0;
    sk_pulses = 0;
    for (int cyc = 0; cyc < 40000 && sk_carries < 12005; cyc++) begin
      @(negedge clk);
      sk_cy = 1'($urandom_range(0, 1));
      drive(1'b0, 1'b0, 1'b0, 1'b0, sk_cy);
      #1;
      sk_co = sk_cy && (sk_m == 12) && (sk_y == 2999);
      check("soak carry_out", int'(bus.carry_out), int'(sk_co));
      if (bus.carry_out) sk_pulses++;
      @(posedge clk);
      #1;
      if (sk_cy) begin
        sk_carries++;
        if (sk_m == 12) begin
          sk_m = 1;
          sk_y = (sk_y == 2999) ? 2000 : sk_y + 1;
        end else begin
          sk_m = sk_m + 1;
        end
      end
      check("soak month", int'(bus.month_count), sk_m);
      check("soak year",  int'(bus.year_count), sk_y);
      check("soak leap",  int'(bus.is_leap_year), int'(ref_leap(sk_y)));
    end
    check("soak carries applied", sk_carries, 12005);
    check("soak carry_out pulses", sk_pulses, 1);

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
